mem_responder: RTL and testbench



---
 rtl/mem_responder_pkg.sv | 23 ++
 rtl/mem_scan_counter.sv | 31 +++
 rtl/mem_responder.sv | 75 +++++++
 tb/tb_mem_responder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types, default sizes and the init-value function for mem_responder.
// Build option: MEM_RESPONDER_INIT_PATTERN_EN selects the address-tag init pattern.
package mem_responder_pkg;

  localparam int AW_DEF       = 4;
  localparam int DW_DEF       = 8;
  localparam int SCAN_DIV_DEF = 16;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Callers size the result down to their data width.
  function automatic int unsigned init_value(input int unsigned idx);
`ifdef MEM_RESPONDER_INIT_PATTERN_EN
    return idx;
`else
    return idx & 32'd0;
`endif
  endfunction

endpackage

// File: rtl/mem_scan_counter.sv
// Free-running scan address generator: divider plus wrapping scan address,
// advancing only while enabled.
module mem_scan_counter #(
  parameter int AW       = 4,
  parameter int SCAN_DIV = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [AW-1:0] scan_a
);

  localparam int DIVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DIVW-1:0] div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div    <= '0;
      scan_a <= '0;
    end else if (en) begin
      if (div == DIVW'(SCAN_DIV - 1)) begin
        div    <= '0;
        scan_a <= scan_a + 1'b1;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: 2**AW x DW store with a registered controller port,
// a registered scan port, and a post-reset init sequencer (MEM_RESPONDER_INIT_PATTERN_EN).
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int SCAN_DIV = SCAN_DIV_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] a,
  input  logic [DW-1:0] din,
  input  logic          we,
  output logic [DW-1:0] dout,
  output logic          ready,
  output logic [AW-1:0] scan_a,
  output logic [DW-1:0] scan_data,
  output state_t        state_dbg
);

  logic [DW-1:0] mem [0:2**AW-1];
  state_t        state;
  logic [AW-1:0] init_ptr;
  logic [DW-1:0] init_word;

  assign init_word = DW'(init_value(32'(init_ptr)));
  assign state_dbg = state;

  mem_scan_counter #(
    .AW       (AW),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (ready),
    .scan_a (scan_a)
  );

  // Storage has no reset; the sequencer rewrites every word after each reset.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[init_ptr] <= init_word;
    end else if (we) begin
      mem[a] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      init_ptr  <= '0;
      ready     <= 1'b0;
      dout      <= '0;
      scan_data <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          init_ptr <= init_ptr + 1'b1;
          if (init_ptr == '1) begin
            state <= ST_READY;
            ready <= 1'b1;
          end
        end
        ST_READY: begin
          // Write-through: a write in this cycle overrides the stored word on both ports.
          dout      <= we ? din : mem[a];
          scan_data <= (we && (a == scan_a)) ? din : mem[scan_a];
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a cycle-count based
// reference model of the store, the init sequence and the scan sweep.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int AW       = 4;
  localparam int DW       = 8;
  localparam int SCAN_DIV = 16;
  localparam int DEPTH    = 2**AW;

  // Handshake: no valid/ready pair; `we` is sampled every rising edge, and
  // `ready` only reports that the init sweep is done.

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] a;
  logic [DW-1:0] din;
  logic          we;
  logic [DW-1:0] dout;
  logic          ready;
  logic [AW-1:0] scan_a;
  logic [DW-1:0] scan_data;
  state_t        state_dbg;

  mem_responder #(.AW(AW), .DW(DW), .SCAN_DIV(SCAN_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .din       (din),
    .we        (we),
    .dout      (dout),
    .ready     (ready),
    .scan_a    (scan_a),
    .scan_data (scan_data),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mm [DEPTH];
  bit            m_ready;
  int            init_cnt;
  int            rc;  // cycles since ready rose

  function automatic logic [DW-1:0] init_of(input int i);
`ifdef MEM_RESPONDER_INIT_PATTERN_EN
    return DW'(i);
`else
    return (i == -1) ? 8'hEE : 8'h00;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    we  = w;
    a   = ad;
    din = d;
  endtask

  function automatic logic [AW-1:0] model_scan_a();
    return m_ready ? AW'((rc / SCAN_DIV) % DEPTH) : '0;
  endfunction

  // Advance one clock with the currently driven inputs and check all outputs.
  task automatic cycle();
    logic [DW-1:0] es;
    logic [AW-1:0] sa;
    if (m_ready) begin
      sa = model_scan_a();
      exp_q.push_back(we ? din : mm[a]);
      es = (we && a == sa) ? din : mm[sa];
      if (we) mm[a] = din;
      rc++;
    end else begin
      exp_q.push_back('0);
      es = '0;
      mm[init_cnt] = init_of(init_cnt);
      init_cnt++;
      if (init_cnt == DEPTH) begin
        m_ready = 1'b1;
        rc = 0;
      end
    end
    @(posedge clk);
    #1;
    check("ready", ready, m_ready);
    check("state", state_dbg, m_ready ? ST_READY : ST_INIT);
    check("dout", dout, exp_q.pop_front());
    check("scan_a", scan_a, model_scan_a());
    check("scan_data", scan_data, es);
  endtask

  task automatic model_reset();
    m_ready  = 1'b0;
    init_cnt = 0;
    rc       = 0;
    exp_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_scan_a"}, scan_a, 0);
    check({tag, "_scan_data"}, scan_data, 0);
    check({tag, "_state"}, state_dbg, ST_INIT);
  endtask

  // Run the init sweep with we held high and random a/din; ready must rise after DEPTH cycles.
  task automatic run_init(input string tag);
    int n = 0;
    while (!m_ready && n < DEPTH + 8) begin
      drive(1'b1, AW'($urandom_range(0, DEPTH-1)), DW'($urandom));
      cycle();
      n++;
    end
    check({tag, "_init_cycles"}, n, DEPTH);
    check({tag, "_ready_up"}, ready, 1);
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, AW'(i), DW'($urandom));
      cycle();
      check({tag, "_init_word"}, dout, init_of(i));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    rst_n = 1'b0;
    drive(1'b1, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    @(negedge clk);
    rst_n = 1'b1;

    run_init("boot");
    read_all("boot");

    // write then read, write-through
    drive(1'b1, 4'd5, 8'h3C); cycle();
    check("wt_3c", dout, 8'h3C);
    drive(1'b0, 4'd5, 8'h00); cycle();
    check("rd_3c", dout, 8'h3C);
    drive(1'b1, 4'd5, 8'h7F); cycle();
    check("wt_7f", dout, 8'h7F);

    // back-to-back writes to the same address
    drive(1'b1, 4'd9, 8'h01); cycle();
    check("b2b_first", dout, 8'h01);
    drive(1'b1, 4'd9, 8'h02); cycle();
    check("b2b_second", dout, 8'h02);
    drive(1'b0, 4'd0, 8'h00); cycle();
    drive(1'b0, 4'd9, 8'h00); cycle();
    check("b2b_last_wins", dout, 8'h02);

    // scan collision
    drive(1'b1, model_scan_a(), 8'hA5); cycle();
    check("scan_collide", scan_data, 8'hA5);

    // random traffic, long enough to cover a full scan wrap
    for (int i = 0; i < 320; i++) begin
      drive(($urandom_range(0, 3) == 0), AW'($urandom_range(0, DEPTH-1)), DW'($urandom));
      cycle();
    end
    check("scan_wrapped", (rc >= SCAN_DIV * DEPTH), 1);

    // mid-operation reset after writing 0xFF to address 3
    drive(1'b1, 4'd3, 8'hFF); cycle();
    drive(1'b0, 4'd3, 8'h00); cycle();
    check("pre_rst_ff", dout, 8'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_init("rerun");
    drive(1'b0, 4'd3, 8'h00); cycle();
    check("a3_reinit", dout, init_of(3));
    read_all("rerun");

    for (int i = 0; i < 60; i++) begin
      drive(($urandom_range(0, 1) == 0), AW'($urandom_range(0, DEPTH-1)), DW'($urandom));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
